// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the LDUR/STUR path.
// Requests are accepted on a valid/ready channel, the access is performed
// on an internal 64-bit word array after LATENCY cycles, and the result is
// returned on a valid/ready response channel. One request is in flight at
// a time, so read-after-write needs no bypass logic.
//
// Handshake rule for both channels: a transfer happens on a rising edge
// where valid and ready are both 1. The master keeps its payload stable
// while valid is high, and valid may stay high across any number of cycles
// with ready low. The FSM state is visible as state_q for bound checkers.
module dmem_responder #(
    parameter int DEPTH      = 128,
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [63:0]           req_wdata,
    input  logic [7:0]            req_bmask,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [63:0]           resp_rdata,
    output logic                  resp_err,
    output logic                  busy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    write_q, write_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [63:0]             wdata_q, wdata_d;
    logic [7:0]              bmask_q, bmask_d;
    logic                    resp_valid_q, resp_valid_d;
    logic [63:0]             rdata_q, rdata_d;
    logic                    err_q, err_d;

    logic [63:0]             mem [DEPTH];

    logic [31:0]             word_idx;
    logic [IDX_W-1:0]        mem_idx;
    logic                    acc_err;
    logic                    do_access;
    logic                    mem_we;
    logic [63:0]             mem_rd;
    logic [63:0]             merged;

    // Word index and error decode from the latched request address.
    assign word_idx  = 32'(addr_q[ADDR_WIDTH-1:3]);
    assign mem_idx   = word_idx[IDX_W-1:0];
    assign acc_err   = (addr_q[2:0] != 3'b000) || (word_idx >= 32'(DEPTH));
    assign do_access = (state_q == S_WAIT) && (cnt_q == 4'd0);
    assign mem_we    = reset && do_access && write_q && !acc_err;
    assign mem_rd    = mem[mem_idx];

    // Byte-merge of store data into the addressed word.
    always_comb begin
        merged = mem_rd;
        for (int i = 0; i < 8; i++) begin
            if (bmask_q[i]) begin
                merged[8*i +: 8] = wdata_q[8*i +: 8];
            end
        end
    end

    // Next-state and next-output computation for the request/response FSM.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        bmask_d      = bmask_q;
        resp_valid_d = resp_valid_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    bmask_d = req_bmask;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    err_d        = acc_err;
                    rdata_d      = (acc_err || write_q) ? 64'd0 : mem_rd;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d      = S_IDLE;
                    resp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d      = S_IDLE;
                resp_valid_d = 1'b0;
            end
        endcase
    end

    // Control and response registers; reset wins over every other event.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= 64'd0;
            bmask_q      <= 8'd0;
            resp_valid_q <= 1'b0;
            rdata_q      <= 64'd0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            bmask_q      <= bmask_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    // Word array: not cleared by reset, written only when a store commits.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_idx] <= merged;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 instance with an 11-bit address
// (so byte address 0x400 lies past the 128-word array) and a LATENCY=1
// instance for back-to-back spacing. Expected data comes from a plain
// word-array model of the memory.
module tb_dmem_responder;

  logic clk;
  logic reset;
  int   cyc;
  int   total;
  int   bad;

  // Instance A: LATENCY=2, ADDR_WIDTH=11
  logic        a_req_valid, a_req_ready, a_req_write;
  logic [10:0] a_req_addr;
  logic [63:0] a_req_wdata;
  logic [7:0]  a_req_bmask;
  logic        a_resp_valid, a_resp_ready, a_resp_err, a_busy;
  logic [63:0] a_resp_rdata;

  // Instance B: LATENCY=1, ADDR_WIDTH=10
  logic        b_req_valid, b_req_ready, b_req_write;
  logic [9:0]  b_req_addr;
  logic [63:0] b_req_wdata;
  logic [7:0]  b_req_bmask;
  logic        b_resp_valid, b_resp_ready, b_resp_err, b_busy;
  logic [63:0] b_resp_rdata;

  logic [63:0] model_mem [128];

  dmem_responder #(.DEPTH(128), .ADDR_WIDTH(11), .LATENCY(2)) u_dut_a (
    .clk(clk), .reset(reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_bmask(a_req_bmask),
    .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
    .resp_rdata(a_resp_rdata), .resp_err(a_resp_err), .busy(a_busy)
  );

  dmem_responder #(.DEPTH(128), .ADDR_WIDTH(10), .LATENCY(1)) u_dut_b (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_bmask(b_req_bmask),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err), .busy(b_busy)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: apply one completed access, return expected response.
  function automatic void model_apply(input logic w, input logic [10:0] a,
                                      input logic [63:0] d, input logic [7:0] m,
                                      output logic [63:0] exp_rd, output logic exp_err);
    int idx;
    idx = int'(a) / 8;
    exp_err = (int'(a) % 8 != 0) || (idx >= 128);
    exp_rd = 64'd0;
    if (!exp_err) begin
      if (w) begin
        for (int i = 0; i < 8; i++)
          if (m[i]) model_mem[idx][8*i +: 8] = d[8*i +: 8];
      end else begin
        exp_rd = model_mem[idx];
      end
    end
  endfunction

  // Driver: present a request and return just after the accepting edge.
  task automatic send_req(input logic w, input logic [10:0] a, input logic [63:0] d,
                          input logic [7:0] m, output bit ok);
    int n;
    a_req_write = w; a_req_addr = a; a_req_wdata = d; a_req_bmask = m;
    a_req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!a_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = a_req_ready;
    @(posedge clk);
    #1;
    a_req_valid = 1'b0;
    // scramble the payload; it must not matter after the accept
    a_req_write = 1'($urandom_range(0, 1));
    a_req_addr  = 11'($urandom);
    a_req_wdata = {$urandom, $urandom};
    a_req_bmask = 8'($urandom);
  endtask

  // Driver: count edges from the accept until resp_valid is seen (at a negedge).
  task automatic wait_resp(output int lat, output bit ok);
    bit seen;
    lat = 0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (a_resp_valid) seen = 1'b1;
    end
    ok = seen;
  endtask

  // Driver: one full transaction with resp_ready high.
  task automatic xact(input logic w, input logic [10:0] a, input logic [63:0] d,
                      input logic [7:0] m, output logic [63:0] rd, output logic e,
                      output int lat, output bit ok);
    rd = 64'hx; e = 1'bx; lat = -1;
    send_req(w, a, d, m, ok);
    if (ok) wait_resp(lat, ok);
    if (ok) begin
      rd = a_resp_rdata;
      e  = a_resp_err;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (a_resp_valid !== 1'b0 || a_resp_rdata !== 64'd0 || a_resp_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_a_resp got v=%b d=%h e=%b want 0/0/0", a_resp_valid, a_resp_rdata, a_resp_err);
    end
    total++;
    if (a_req_ready !== 1'b1 || a_busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_a_idle got rdy=%b busy=%b want 1/0", a_req_ready, a_busy);
    end
    total++;
    if (b_resp_valid !== 1'b0 || b_resp_rdata !== 64'd0 || b_resp_err !== 1'b0 ||
        b_req_ready !== 1'b1 || b_busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_b got v=%b d=%h e=%b rdy=%b busy=%b", b_resp_valid, b_resp_rdata,
               b_resp_err, b_req_ready, b_busy);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_init;
    logic [63:0] rd, exp_rd, d;
    logic e, exp_e;
    int lat;
    bit ok;
    for (int i = 0; i < 128; i++) begin
      d = {$urandom, $urandom};
      xact(1'b1, 11'(i * 8), d, 8'hFF, rd, e, lat, ok);
      model_apply(1'b1, 11'(i * 8), d, 8'hFF, exp_rd, exp_e);
      total++;
      if (!ok || rd !== exp_rd || e !== exp_e || lat !== 2) begin
        bad++;
        $display("FAIL init_store[%0d] got ok=%0d d=%h e=%b lat=%0d want d=%h e=%b lat=2",
                 i, ok, rd, e, lat, exp_rd, exp_e);
      end
    end
  endtask

  task automatic test_store_load;
    logic [63:0] rd, exp_rd;
    logic e, exp_e;
    int lat;
    bit ok;
    xact(1'b1, 11'h010, 64'h1122334455667788, 8'hFF, rd, e, lat, ok);
    model_apply(1'b1, 11'h010, 64'h1122334455667788, 8'hFF, exp_rd, exp_e);
    total++;
    if (!ok || lat !== 2 || rd !== 64'd0 || e !== 1'b0) begin
      bad++;
      $display("FAIL store_010 got ok=%0d lat=%0d d=%h e=%b want lat=2 d=0 e=0", ok, lat, rd, e);
    end
    xact(1'b0, 11'h010, 64'd0, 8'h00, rd, e, lat, ok);
    model_apply(1'b0, 11'h010, 64'd0, 8'h00, exp_rd, exp_e);
    total++;
    if (!ok || lat !== 2 || rd !== 64'h1122334455667788 || e !== 1'b0) begin
      bad++;
      $display("FAIL load_010 got ok=%0d lat=%0d d=%h e=%b want lat=2 d=1122334455667788 e=0",
               ok, lat, rd, e);
    end
  endtask

  task automatic test_partial;
    logic [63:0] rd, exp_rd;
    logic e, exp_e;
    int lat;
    bit ok;
    xact(1'b1, 11'h010, 64'hAAAAAAAAAAAAAAAA, 8'h0F, rd, e, lat, ok);
    model_apply(1'b1, 11'h010, 64'hAAAAAAAAAAAAAAAA, 8'h0F, exp_rd, exp_e);
    xact(1'b0, 11'h010, 64'd0, 8'hFF, rd, e, lat, ok);
    model_apply(1'b0, 11'h010, 64'd0, 8'hFF, exp_rd, exp_e);
    total++;
    if (!ok || rd !== 64'h11223344AAAAAAAA || e !== 1'b0) begin
      bad++;
      $display("FAIL partial_merge got ok=%0d d=%h e=%b want d=11223344aaaaaaaa e=0", ok, rd, e);
    end
    // store with all byte enables off is a no-op that still responds cleanly
    xact(1'b1, 11'h010, 64'hFFFFFFFFFFFFFFFF, 8'h00, rd, e, lat, ok);
    model_apply(1'b1, 11'h010, 64'hFFFFFFFFFFFFFFFF, 8'h00, exp_rd, exp_e);
    total++;
    if (!ok || rd !== 64'd0 || e !== 1'b0 || lat !== 2) begin
      bad++;
      $display("FAIL zero_mask_resp got ok=%0d d=%h e=%b lat=%0d want d=0 e=0 lat=2", ok, rd, e, lat);
    end
    xact(1'b0, 11'h010, 64'd0, 8'h00, rd, e, lat, ok);
    total++;
    if (!ok || rd !== 64'h11223344AAAAAAAA) begin
      bad++;
      $display("FAIL zero_mask_nochange got d=%h want 11223344aaaaaaaa", rd);
    end
  endtask

  task automatic test_errors;
    logic [63:0] rd;
    logic e;
    int lat;
    bit ok;
    xact(1'b0, 11'h013, 64'd0, 8'hFF, rd, e, lat, ok);
    total++;
    if (!ok || e !== 1'b1 || rd !== 64'd0 || lat !== 2) begin
      bad++;
      $display("FAIL misaligned_load got ok=%0d d=%h e=%b lat=%0d want d=0 e=1 lat=2", ok, rd, e, lat);
    end
    xact(1'b0, 11'h400, 64'd0, 8'hFF, rd, e, lat, ok);
    total++;
    if (!ok || e !== 1'b1 || rd !== 64'd0) begin
      bad++;
      $display("FAIL oor_load got ok=%0d d=%h e=%b want d=0 e=1", ok, rd, e);
    end
    // erroring stores must not touch the array
    xact(1'b1, 11'h013, 64'h0123456789ABCDEF, 8'hFF, rd, e, lat, ok);
    total++;
    if (!ok || e !== 1'b1 || rd !== 64'd0) begin
      bad++;
      $display("FAIL misaligned_store got ok=%0d d=%h e=%b want d=0 e=1", ok, rd, e);
    end
    xact(1'b1, 11'h410, 64'h0123456789ABCDEF, 8'hFF, rd, e, lat, ok);
    xact(1'b0, 11'h010, 64'd0, 8'h00, rd, e, lat, ok);
    total++;
    if (!ok || rd !== 64'h11223344AAAAAAAA || e !== 1'b0) begin
      bad++;
      $display("FAIL err_nochange_010 got d=%h e=%b want 11223344aaaaaaaa/0", rd, e);
    end
    xact(1'b0, 11'h018, 64'd0, 8'h00, rd, e, lat, ok);
    total++;
    if (!ok || rd !== model_mem[3] || e !== 1'b0) begin
      bad++;
      $display("FAIL err_nochange_018 got d=%h e=%b want %h/0", rd, e, model_mem[3]);
    end
  endtask

  task automatic test_backpressure;
    logic [63:0] rd0;
    logic e0;
    int lat;
    bit ok;
    a_resp_ready = 1'b0;
    send_req(1'b0, 11'h010, 64'd0, 8'h00, ok);
    if (ok) wait_resp(lat, ok);
    total++;
    if (!ok || lat !== 2 || a_resp_rdata !== 64'h11223344AAAAAAAA || a_resp_err !== 1'b0) begin
      bad++;
      $display("FAIL bp_first got ok=%0d lat=%0d d=%h e=%b want lat=2 d=11223344aaaaaaaa e=0",
               ok, lat, a_resp_rdata, a_resp_err);
    end
    rd0 = 64'h11223344AAAAAAAA;
    e0  = 1'b0;
    a_req_valid = 1'b1;  // a waiting request must not sneak in while busy
    a_req_write = 1'b1; a_req_addr = 11'h010; a_req_wdata = 64'd0; a_req_bmask = 8'hFF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if (a_resp_valid !== 1'b1 || a_resp_rdata !== rd0 || a_resp_err !== e0 || a_req_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold[%0d] got v=%b d=%h e=%b rdy=%b want 1/%h/%b/0",
                 k, a_resp_valid, a_resp_rdata, a_resp_err, a_req_ready, rd0, e0);
      end
    end
    a_req_valid = 1'b0;
    a_resp_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    total++;
    if (a_resp_valid !== 1'b0 || a_req_ready !== 1'b1 || a_busy !== 1'b0) begin
      bad++;
      $display("FAIL bp_release got v=%b rdy=%b busy=%b want 0/1/0", a_resp_valid, a_req_ready, a_busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_in_wait;
    logic [63:0] rd, exp_rd;
    logic e, exp_e;
    int lat;
    bit ok;
    xact(1'b1, 11'h020, 64'h5, 8'hFF, rd, e, lat, ok);
    model_apply(1'b1, 11'h020, 64'h5, 8'hFF, exp_rd, exp_e);
    send_req(1'b1, 11'h020, 64'hDEAD, 8'hFF, ok);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (!ok || a_resp_valid !== 1'b0 || a_busy !== 1'b0 || a_req_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_wait_idle got ok=%0d v=%b busy=%b rdy=%b want 0/0/1",
               ok, a_resp_valid, a_busy, a_req_ready);
    end
    repeat (4) @(negedge clk);
    total++;
    if (a_resp_valid !== 1'b0 || a_busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_wait_quiet got v=%b busy=%b want 0/0", a_resp_valid, a_busy);
    end
    @(posedge clk);
    #1;
    xact(1'b0, 11'h020, 64'd0, 8'h00, rd, e, lat, ok);
    total++;
    if (!ok || rd !== 64'h5 || e !== 1'b0) begin
      bad++;
      $display("FAIL rst_wait_nocommit got d=%h e=%b want 5/0", rd, e);
    end
  endtask

  task automatic test_random;
    logic [63:0] rd, exp_rd, d;
    logic [10:0] a;
    logic [7:0] m;
    logic w, e, exp_e;
    int lat, kind;
    bit ok;
    for (int i = 0; i < 150; i++) begin
      w = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 9);
      if (kind == 0)      a = 11'($urandom_range(0, 2047) | 1);
      else if (kind == 1) a = 11'($urandom_range(128, 255) * 8);
      else                a = 11'($urandom_range(0, 127) * 8);
      d = {$urandom, $urandom};
      m = 8'($urandom);
      xact(w, a, d, m, rd, e, lat, ok);
      model_apply(w, a, d, m, exp_rd, exp_e);
      total++;
      if (!ok || rd !== exp_rd || e !== exp_e || lat !== 2) begin
        bad++;
        $display("FAIL rand[%0d] w=%b a=%h m=%h got ok=%0d d=%h e=%b lat=%0d want d=%h e=%b lat=2",
                 i, w, a, m, ok, rd, e, lat, exp_rd, exp_e);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic        op_w  [6];
    logic [9:0]  op_a  [6];
    logic [63:0] op_d  [6];
    logic [63:0] exp_q [$];
    int acc_cyc [6];
    int rsp_cyc [6];
    logic [63:0] rsp_d [6];
    int na, nr;
    bit acc_now;
    op_a[0] = 10'h008; op_a[1] = 10'h018; op_a[2] = 10'h3F8;
    for (int k = 0; k < 3; k++) begin
      op_w[k] = 1'b1;
      op_d[k] = {$urandom, $urandom};
      op_w[k+3] = 1'b0;
      op_a[k+3] = op_a[k];
      op_d[k+3] = 64'd0;
    end
    for (int k = 0; k < 3; k++) exp_q.push_back(64'd0);
    for (int k = 0; k < 3; k++) exp_q.push_back(op_d[k]);
    na = 0; nr = 0;
    b_resp_ready = 1'b1;
    b_req_write = op_w[0]; b_req_addr = op_a[0]; b_req_wdata = op_d[0]; b_req_bmask = 8'hFF;
    b_req_valid = 1'b1;
    for (int t = 0; t < 60 && nr < 6; t++) begin
      @(negedge clk);
      if (b_resp_valid) begin
        rsp_cyc[nr] = cyc;
        rsp_d[nr] = b_resp_rdata;
        nr++;
      end
      acc_now = b_req_valid && b_req_ready;
      @(posedge clk);
      #1;
      if (acc_now && na < 6) begin
        acc_cyc[na] = cyc;
        na++;
        if (na < 6) begin
          b_req_write = op_w[na]; b_req_addr = op_a[na]; b_req_wdata = op_d[na];
        end else begin
          b_req_valid = 1'b0;
        end
      end
    end
    b_req_valid = 1'b0;
    total++;
    if (na !== 6 || nr !== 6) begin
      bad++;
      $display("FAIL b2b_count got accepts=%0d resps=%0d want 6/6", na, nr);
    end else begin
      for (int k = 0; k < 6; k++) begin
        total++;
        if (rsp_cyc[k] - acc_cyc[k] !== 1) begin
          bad++;
          $display("FAIL b2b_lat[%0d] got=%0d want=1", k, rsp_cyc[k] - acc_cyc[k]);
        end
        total++;
        if (rsp_d[k] !== exp_q[k]) begin
          bad++;
          $display("FAIL b2b_data[%0d] got=%h want=%h", k, rsp_d[k], exp_q[k]);
        end
        if (k > 0) begin
          total++;
          if (acc_cyc[k] - acc_cyc[k-1] !== 3) begin
            bad++;
            $display("FAIL b2b_spacing[%0d] got=%0d want=3", k, acc_cyc[k] - acc_cyc[k-1]);
          end
        end
      end
    end
  endtask

  initial begin
    cyc = 0; total = 0; bad = 0;
    reset = 1'b0;
    a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_req_bmask = '0;
    a_resp_ready = 1'b1;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_bmask = '0;
    b_resp_ready = 1'b1;
    test_reset;
    test_init;
    test_store_load;
    test_partial;
    test_errors;
    test_backpressure;
    test_reset_in_wait;
    test_random;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
